// File: rtl/attn_out_requant_pkg.sv
// Shared types and width helpers for the attention-output requantiser.
package attn_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } req_state_t;

    // Width of a raw attention accumulator element.
    function automatic int attn_ow(input int dw, input int frac_w, input int seq_len);
        return dw + frac_w + $clog2(seq_len);
    endfunction

endpackage

// File: rtl/attn_out_requant_sat.sv
// requant_sat: round-half-up by FRAC_W bits, then clamp to signed DW; sat flags a clamp.
// Latency: combinational. Backpressure: none.
module requant_sat #(
    parameter int OW     = 19,
    parameter int DW     = 4,
    parameter int FRAC_W = 4
) (
    input  logic signed [OW-1:0] x,
    output logic        [DW-1:0] y,
    output logic                 sat
);

    localparam logic signed [OW:0] RND_V = (OW+1)'(1 << (FRAC_W-1));
    localparam logic signed [OW:0] MAX_V = (OW+1)'((1 << (DW-1)) - 1);
    localparam logic signed [OW:0] MIN_V = ~MAX_V;

    logic signed [OW:0] ext;
    logic signed [OW:0] rnd;
    logic signed [OW:0] shv;

    // One extra bit keeps the rounding add from wrapping at the positive extreme.
    always_comb begin
        ext = {x[OW-1], x};
        rnd = ext + RND_V;
        shv = rnd >>> FRAC_W;
        y   = shv[DW-1:0];
        sat = 1'b0;
        if (shv > MAX_V) begin
            y   = MAX_V[DW-1:0];
            sat = 1'b1;
        end else if (shv < MIN_V) begin
            y   = MIN_V[DW-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/attn_out_requant.sv
// attn_out_requant: requantise captured per-head vectors into a 2-slot ping-pong store, stream one head per beat.
// Latency: out_valid one cycle after the capture edge. Backpressure: out_ready stalls the stream; a capture
// into a full store (with no freeing beat) is dropped and sets sticky ovf. Optional ATTN_REQ_SATCNT_EN adds sat_cnt.
module attn_out_requant
    import attn_pkg::*;
#(
    parameter  int HEADS   = 12,
    parameter  int SEQ_LEN = 2048,
    parameter  int DW      = 4,
    parameter  int FRAC_W  = 4,
    localparam int OW      = attn_ow(DW, FRAC_W, SEQ_LEN),
    localparam int HW      = $clog2(HEADS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [0:HEADS-1][OW-1:0]  in_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW-1:0]             out_data,
    output logic [HW-1:0]             out_head,
    output logic                      out_last,
    output logic [1:0]                buf_cnt,
    output logic                      ovf
`ifdef ATTN_REQ_SATCNT_EN
   ,output logic [15:0]               sat_cnt
`endif
);

    logic [DW-1:0] rq_vec [HEADS];
    logic [HEADS-1:0] sat_vec;
    logic [DW-1:0] mem_q [2][HEADS];

    req_state_t    state_q, state_d;
    logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [HW-1:0] head_q, head_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          ovf_q, ovf_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic          beat, last_beat, cap;

    for (genvar g = 0; g < HEADS; g++) begin : g_rq
        requant_sat #(.OW(OW), .DW(DW), .FRAC_W(FRAC_W)) u_rq (
            .x   (in_vec[g]),
            .y   (rq_vec[g]),
            .sat (sat_vec[g])
        );
    end

    // A capture alongside the final beat of the oldest vector reuses the slot it frees.
    always_comb begin
        beat        = out_valid_q & out_ready;
        last_beat   = beat & out_last_q;
        cap         = in_valid & ((cnt_q != 2'd2) | last_beat);
        ovf_d       = ovf_q | (in_valid & ~cap);
        cnt_d       = cnt_q + {1'b0, cap} - {1'b0, last_beat};
        wr_ptr_d    = wr_ptr_q ^ cap;
        rd_ptr_d    = rd_ptr_q ^ last_beat;
        head_d      = head_q;
        if (last_beat) begin
            head_d = '0;
        end else if (beat) begin
            head_d = head_q + 1'b1;
        end
        state_d     = (cnt_d != 2'd0) ? STREAM : IDLE;
        out_valid_d = (cnt_d != 2'd0);
        out_last_d  = (cnt_d != 2'd0) && (head_d == HW'(HEADS-1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            head_q      <= '0;
            cnt_q       <= 2'd0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            head_q      <= head_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Slot contents need no reset: they are only visible while the matching count is non-zero.
    always_ff @(posedge clk) begin
        if (cap) begin
            mem_q[wr_ptr_q] <= rq_vec;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = (state_q == STREAM) ? mem_q[rd_ptr_q][head_q] : '0;
    assign out_head  = head_q;
    assign out_last  = out_last_q;
    assign buf_cnt   = cnt_q;
    assign ovf       = ovf_q;

`ifdef ATTN_REQ_SATCNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;
    logic [HW:0] nsat;
    logic [16:0] sat_sum;

    always_comb begin
        nsat = '0;
        for (int i = 0; i < HEADS; i++) begin
            nsat = nsat + (HW+1)'(sat_vec[i]);
        end
        sat_sum   = {1'b0, sat_cnt_q} + 17'(nsat);
        sat_cnt_d = sat_cnt_q;
        if (cap) begin
            sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt_q <= 16'd0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    logic unused_sat;
    assign unused_sat = ^sat_vec;
`endif

endmodule
